// File: rtl/sha2_msg_padder_if.sv
// Byte-stream input and padded-block output of the SHA-256 message padder.
// master: message source / block consumer side; slave: the padder itself.
interface sha2_msg_padder_if;
  logic [7:0]   in_data;
  logic         in_valid;
  logic         in_last;
  logic         in_ready;
  logic [511:0] blk_data;
  logic         blk_valid;
  logic         blk_ready;
  logic         blk_first;
  logic         blk_last;
  logic         busy;

  modport master (
    output in_data, in_valid, in_last, blk_ready,
    input  in_ready, blk_data, blk_valid, blk_first, blk_last, busy
  );

  modport slave (
    input  in_data, in_valid, in_last, blk_ready,
    output in_ready, blk_data, blk_valid, blk_first, blk_last, busy
  );
endinterface

// File: rtl/sha2_msg_padder.sv
// SHA-256 message padder: packs a byte stream into 512-bit blocks and appends
// the 0x80 marker, zero fill and 64-bit big-endian bit length. A block is held
// on blk_data until the consumer takes it; a trailing length-only block follows
// back-to-back when the final data block has no room for the length field.
module sha2_msg_padder #(
  parameter int LEN_W = 64
) (
  input  logic             clk,
  input  logic             rst,
  sha2_msg_padder_if.slave bus
);

  typedef enum logic {
    FILL = 1'b0,
    EMIT = 1'b1
  } state_t;

  state_t           state_reg, state_next;
  logic [5:0]       idx_reg, idx_next;
  logic [LEN_W-1:0] bitcnt_reg, bitcnt_next, bitcnt_inc;
  logic             pad_pending_reg, pad_pending_next;
  logic             pad_lead_reg, pad_lead_next;
  logic             first_reg, first_next;
  logic             blk_first_reg, blk_first_next;
  logic             blk_last_reg, blk_last_next;
  logic             busy_reg, busy_next;
  logic             in_ready_reg;

  logic [7:0]       blk_reg  [64];
  logic [7:0]       blk_next [64];

  logic [6:0]       n_bytes;
  logic             accept;
  logic             pad_load;

  // n_bytes is the byte count of the current block including the byte being accepted
  assign accept     = bus.in_valid & in_ready_reg;
  assign pad_load   = (state_reg == EMIT) & bus.blk_ready & pad_pending_reg;
  assign n_bytes    = {1'b0, idx_reg} + 7'd1;
  assign bitcnt_inc = bitcnt_reg + LEN_W'(8);

  assign bus.in_ready  = in_ready_reg;
  assign bus.blk_valid = (state_reg == EMIT);
  assign bus.blk_first = blk_first_reg;
  assign bus.blk_last  = blk_last_reg;
  assign bus.busy      = busy_reg;

  // Per-byte next value of the block buffer: data byte, 0x80 marker, zero fill,
  // length field, or the contents of the trailing length-only block.
  for (genvar gi = 0; gi < 64; gi++) begin : g_byte
    logic [7:0] len_cur;
    logic [7:0] len_inc;
    logic [7:0] fill_val;

    if (gi >= 56) begin : g_len
      assign len_cur = bitcnt_reg[8*(63-gi) +: 8];
      assign len_inc = bitcnt_inc[8*(63-gi) +: 8];
    end else begin : g_nolen
      assign len_cur = 8'h00;
      assign len_inc = 8'h00;
    end

    // Select the value this byte takes at the next clock edge
    always_comb begin
      fill_val = blk_reg[gi];
      if (pad_load) begin
        if (gi == 0) begin
          fill_val = pad_lead_reg ? 8'h80 : 8'h00;
        end else if (gi >= 56) begin
          fill_val = len_cur;
        end else begin
          fill_val = 8'h00;
        end
      end else if (accept) begin
        if (idx_reg == 6'(gi)) begin
          fill_val = bus.in_data;
        end else if (bus.in_last && (n_bytes == 7'(gi))) begin
          fill_val = 8'h80;
        end else if (bus.in_last && (n_bytes < 7'(gi))) begin
          // Length fits only when the message ends at byte 55 or earlier
          fill_val = ((gi >= 56) && (n_bytes <= 7'd55)) ? len_inc : 8'h00;
        end
      end
    end

    assign blk_next[gi]                  = fill_val;
    assign bus.blk_data[511-8*gi -: 8]   = blk_reg[gi];
  end

  // Block buffer register; cleared on reset so a held block is discarded
  always_ff @(posedge clk) begin
    for (int k = 0; k < 64; k++) begin
      blk_reg[k] <= rst ? 8'h00 : blk_next[k];
    end
  end

  // Control state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= FILL;
      idx_reg         <= '0;
      bitcnt_reg      <= '0;
      pad_pending_reg <= 1'b0;
      pad_lead_reg    <= 1'b0;
      first_reg       <= 1'b1;
      blk_first_reg   <= 1'b0;
      blk_last_reg    <= 1'b0;
      busy_reg        <= 1'b0;
      in_ready_reg    <= 1'b0;
    end else begin
      state_reg       <= state_next;
      idx_reg         <= idx_next;
      bitcnt_reg      <= bitcnt_next;
      pad_pending_reg <= pad_pending_next;
      pad_lead_reg    <= pad_lead_next;
      first_reg       <= first_next;
      blk_first_reg   <= blk_first_next;
      blk_last_reg    <= blk_last_next;
      busy_reg        <= busy_next;
      in_ready_reg    <= (state_next == FILL);
    end
  end

  // Next-state logic: fill bytes, decide block flags, sequence the pad block
  always_comb begin
    state_next       = state_reg;
    idx_next         = idx_reg;
    bitcnt_next      = bitcnt_reg;
    pad_pending_next = pad_pending_reg;
    pad_lead_next    = pad_lead_reg;
    first_next       = first_reg;
    blk_first_next   = blk_first_reg;
    blk_last_next    = blk_last_reg;
    busy_next        = busy_reg;
    case (state_reg)
      FILL: begin
        if (accept) begin
          idx_next    = idx_reg + 6'd1;
          bitcnt_next = bitcnt_inc;
          busy_next   = 1'b1;
          if (bus.in_last || (n_bytes == 7'd64)) begin
            state_next       = EMIT;
            idx_next         = '0;
            blk_first_next   = first_reg;
            first_next       = 1'b0;
            blk_last_next    = bus.in_last && (n_bytes <= 7'd55);
            pad_pending_next = bus.in_last && (n_bytes > 7'd55);
            pad_lead_next    = (n_bytes == 7'd64);
          end
        end
      end
      EMIT: begin
        if (bus.blk_ready) begin
          if (pad_pending_reg) begin
            pad_pending_next = 1'b0;
            blk_first_next   = 1'b0;
            blk_last_next    = 1'b1;
          end else begin
            state_next = FILL;
            if (blk_last_reg) begin
              bitcnt_next = '0;
              idx_next    = '0;
              busy_next   = 1'b0;
              first_next  = 1'b1;
            end
          end
        end
      end
      default: state_next = FILL;
    endcase
  end

endmodule

// File: tb/tb_sha2_msg_padder.sv
// Randomised scoreboard bench for sha2_msg_padder. Expected blocks come from a
// byte-queue padding model; a monitor compares on every block handshake.
module tb_sha2_msg_padder;

  typedef logic [7:0] bq_t[$];
  typedef struct packed {
    logic [511:0] data;
    logic         first;
    logic         last;
  } exp_t;

  logic clk;
  logic rst;
  sha2_msg_padder_if bus ();

  sha2_msg_padder #(.LEN_W(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  exp_t e_mon;
  int   ready_mode = 0;
  int   hold_cnt   = 0;
  bit   abc_check  = 0;
  logic [513:0] prev_blk;
  logic prev_valid = 0;
  logic prev_ready = 0;
  logic [511:0] abc_block;

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [519:0] act, input logic [519:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference model: pad the whole message as a byte queue, then slice blocks
  task automatic push_expected(input bq_t msg);
    bq_t          p;
    logic [63:0]  bits;
    int           nblk;
    exp_t         e;
    p    = msg;
    bits = 64'(msg.size()) << 3;
    p.push_back(8'h80);
    while ((p.size() % 64) != 56) p.push_back(8'h00);
    for (int i = 7; i >= 0; i--) p.push_back(bits[8*i +: 8]);
    nblk = p.size() / 64;
    for (int b = 0; b < nblk; b++) begin
      e.data = '0;
      for (int k = 0; k < 64; k++) e.data[511-8*k -: 8] = p[64*b+k];
      e.first = (b == 0);
      e.last  = (b == nblk - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic drive_msg(input bq_t msg, input bit mark_last, input int gap_pct);
    for (int i = 0; i < msg.size(); i++) begin
      while (int'($urandom_range(99)) < gap_pct) begin
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        @(posedge clk); #1;
      end
      bus.in_data  = msg[i];
      bus.in_valid = 1'b1;
      bus.in_last  = mark_last && (i == msg.size() - 1);
      do @(negedge clk); while (!bus.in_ready);
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic wait_idle();
    do @(negedge clk); while (exp_q.size() != 0 || bus.blk_valid || bus.busy);
    @(posedge clk); #1;
  endtask

  task automatic run_msg(input bq_t msg, input int gap_pct);
    push_expected(msg);
    drive_msg(msg, 1'b1, gap_pct);
    wait_idle();
  endtask

  function automatic bq_t make_msg(input int len, input bit rnd, input logic [7:0] fillb);
    bq_t q;
    for (int i = 0; i < len; i++) q.push_back(rnd ? 8'($urandom) : fillb);
    return q;
  endfunction

  // Consumer: blk_ready pattern selected by ready_mode
  initial begin
    bus.blk_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0: bus.blk_ready = 1'b1;
        1: bus.blk_ready = ($urandom_range(3) != 0);
        default: begin
          if (bus.blk_valid && hold_cnt < 10) begin
            bus.blk_ready = 1'b0;
            hold_cnt++;
          end else begin
            bus.blk_ready = 1'b1;
            hold_cnt = 0;
          end
        end
      endcase
    end
  end

  // Monitor: stability while held, in_ready exclusion, scoreboard on handshake
  always @(negedge clk) begin
    if (rst) begin
      prev_valid = 1'b0;
      prev_ready = 1'b0;
    end else begin
      if (bus.blk_valid) begin
        chk("in_ready_low_while_held", 520'(bus.in_ready), 520'(1'b0));
        chk("busy_while_held", 520'(bus.busy), 520'(1'b1));
        if (prev_valid && !prev_ready)
          chk("held_block_stable", 520'({bus.blk_data, bus.blk_first, bus.blk_last}), 520'(prev_blk));
        if (bus.blk_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_block actual=%0h required=none", bus.blk_data);
          end else begin
            e_mon = exp_q.pop_front();
            chk("blk_data", 520'(bus.blk_data), 520'(e_mon.data));
            chk("blk_first", 520'(bus.blk_first), 520'(e_mon.first));
            chk("blk_last", 520'(bus.blk_last), 520'(e_mon.last));
            if (abc_check) chk("abc_literal", 520'(bus.blk_data), 520'(abc_block));
          end
        end
      end
      prev_valid = bus.blk_valid;
      prev_ready = bus.blk_ready;
      prev_blk   = {bus.blk_data, bus.blk_first, bus.blk_last};
    end
  end

  // Watchdog bounds every wait in the bench
  initial begin
    repeat (60000) @(posedge clk);
    errors++;
    $display("FAIL watchdog actual=timeout required=completion queued=%0d", exp_q.size());
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    bq_t msg;
    int  lens[11] = '{1, 54, 55, 56, 57, 63, 64, 65, 119, 120, 128};

    abc_block    = {32'h61626380, 416'h0, 64'h18};
    rst          = 1'b1;
    bus.in_data  = 8'h00;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_in_ready", 520'(bus.in_ready), 520'(1'b0));
    chk("reset_outputs", 520'({bus.blk_valid, bus.blk_first, bus.blk_last, bus.busy}), 520'(4'b0));
    chk("reset_blk_data", 520'(bus.blk_data), 520'(0));
    rst = 1'b0;
    @(posedge clk); #1;
    chk("in_ready_after_reset", 520'(bus.in_ready), 520'(1'b1));

    // "abc"
    abc_check = 1;
    msg = '{8'h61, 8'h62, 8'h63};
    run_msg(msg, 0);
    abc_check = 0;

    // 55, 56 and 64 zero bytes
    run_msg(make_msg(55, 0, 8'h00), 0);
    run_msg(make_msg(56, 0, 8'h00), 0);
    run_msg(make_msg(64, 0, 8'h00), 0);

    // 100 bytes with each block held 10 cycles
    ready_mode = 2;
    run_msg(make_msg(100, 1, 8'h00), 20);
    ready_mode = 0;

    // Reset after 30 bytes of a message, then "abc" again
    drive_msg(make_msg(30, 1, 8'h00), 1'b0, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midreset_in_ready", 520'(bus.in_ready), 520'(1'b0));
    chk("midreset_outputs", 520'({bus.blk_valid, bus.busy}), 520'(2'b0));
    rst = 1'b0;
    @(posedge clk); #1;
    chk("midreset_in_ready_rise", 520'(bus.in_ready), 520'(1'b1));
    chk("midreset_busy", 520'(bus.busy), 520'(1'b0));
    abc_check = 1;
    msg = '{8'h61, 8'h62, 8'h63};
    run_msg(msg, 0);
    abc_check = 0;

    // Boundary lengths with random data and random back-pressure
    ready_mode = 1;
    foreach (lens[i]) run_msg(make_msg(lens[i], 1, 8'h00), 25);

    // Fully random messages
    for (int m = 0; m < 15; m++) run_msg(make_msg(int'($urandom_range(1, 200)), 1, 8'h00), 30);

    chk("scoreboard_drained", 520'(exp_q.size()), 520'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
